xy_tag_sched: RTL and testbench
===============================

XY_TAG_SCHED -- requirements
Module: xy_tag_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand width; one payload word is 2*DATA_WIDTH bits.
REQ-002 Parameter NUM_COL, default 4: PE columns on the XY-NoC.
REQ-003 Parameter NUM_ROW, default 4: PE rows on the XY-NoC.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin one convolution window transfer; sampled only in IDLE.
REQ-007 kernel_size  in  8  kernel edge length k; latched on accepted start.
REQ-008 num_channel  in  8  channel count C; latched on accepted start.
REQ-009 fifo_empty  in  1  source FIFO empty flag.
REQ-010 fifo_rd_en  out  1  FIFO pop strobe; read data valid on the following cycle.
REQ-011 fifo_dout  in  2*DATA_WIDTH  FIFO read data.
REQ-012 out_valid  out  1  tagged word valid toward the NoC.
REQ-013 out_ready  in  1  NoC accepts word when out_valid && out_ready.
REQ-014 out_row  out  $clog2(NUM_ROW)+1  destination row ID (1 extra bit).
REQ-015 out_col  out  $clog2(NUM_COL)+1  destination column ID (1 extra bit).
REQ-016 out_data  out  2*DATA_WIDTH  payload.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse after last word accepted.
REQ-019 cfg_err  out  1  one-cycle pulse on rejected start.

Function
REQ-020 FSM states: IDLE, FETCH, WAIT, SEND, DONE.
REQ-021 IDLE: on start, if 1<=k<=min(NUM_COL,NUM_ROW) and C>=1, latch k, C, clear row/col/channel counters, go FETCH; else pulse cfg_err next cycle, stay IDLE.
REQ-022 FETCH: fifo_rd_en=1 combinationally iff !fifo_empty; on pop go WAIT; else remain FETCH (no timeout).
REQ-023 WAIT: register fifo_dout into out_data, current row/col counters into out_row/out_col; go SEND.
REQ-024 SEND: out_valid=1; out_row, out_col, out_data held stable until handshake.
REQ-025 On handshake: col increments; col==k-1 wraps to 0 and row increments; row==k-1 and col==k-1 wraps row to 0 and channel increments.
REQ-026 On handshake of word with channel==C-1, row==k-1, col==k-1: go DONE; otherwise go FETCH, except if !fifo_empty then assert fifo_rd_en in the same cycle and go WAIT directly (sustained rate one word per 2 cycles).
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Exactly k*k*C words emitted per accepted start; exactly k*k*C FIFO pops.
REQ-029 Counters: col, row 8-bit, channel 8-bit; out_row/out_col take low bits of row/col counters, zero-extended.
REQ-030 start while busy is ignored; no cfg_err.
REQ-031 fifo_rd_en never asserted when fifo_empty=1 or outside FETCH/SEND-handshake cycle.
REQ-032 out_valid deasserted in all states except SEND.
REQ-033 Latency: start accepted at cycle 0, with FIFO non-empty fifo_rd_en at cycle 1, out_valid at cycle 3.

Reset
REQ-034 rstn=0 at a clock edge forces IDLE regardless of state, including mid-transfer; latched config and counters cleared.
REQ-035 Reset values: fifo_rd_en=0, out_valid=0, out_row=0, out_col=0, out_data=0, busy=0, done=0, cfg_err=0.
REQ-036 No partial transfer resumes after reset; a new start is required.

Verification
REQ-037 k=2, C=1, FIFO preloaded with 4 words, out_ready=1 -> tags (0,0),(0,1),(1,0),(1,1) in order, data order preserved, done pulse once, 4 pops.
REQ-038 k=3, C=2, out_ready toggled randomly -> 18 words, tags repeat 3x3 sweep twice, outputs stable while stalled.
REQ-039 k=5 with NUM_COL=NUM_ROW=4, or C=0 -> cfg_err single pulse, busy stays 0, no pops.
REQ-040 k=2, C=1, FIFO empty for 10 cycles after start -> FETCH holds, no fifo_rd_en, no out_valid; output resumes when data arrives.
REQ-041 rstn low during SEND of 3rd word (k=3,C=1) -> next cycle all outputs at reset values; following start restarts tags at (0,0).
REQ-042 start asserted during busy -> ignored; word count unchanged.

Source files
------------

// File: rtl/xy_tag_sched.sv
// Window scheduler: pops k*k*C operand words from a FIFO and tags each one with
// its (row, col) destination on the XY-NoC, one word per valid/ready handshake.
module xy_tag_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int NUM_ROW    = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [7:0]                  kernel_size,
    input  logic [7:0]                  num_channel,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [2*DATA_WIDTH-1:0]     fifo_dout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_ROW):0]    out_row,
    output logic [$clog2(NUM_COL):0]    out_col,
    output logic [2*DATA_WIDTH-1:0]     out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err
);

    localparam int RW = $clog2(NUM_ROW) + 1;
    localparam int CW = $clog2(NUM_COL) + 1;
    // Largest kernel that still fits on the PE array in both dimensions.
    localparam logic [7:0] K_MAX = 8'((NUM_COL < NUM_ROW) ? NUM_COL : NUM_ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] k_reg;
    logic [7:0] c_reg;
    logic [7:0] col_cnt;
    logic [7:0] row_cnt;
    logic [7:0] ch_cnt;

    logic       cfg_ok;
    logic       accept;
    logic       cfg_err_next;
    logic       handshake;
    logic       col_last;
    logic       row_last;
    logic       ch_last;
    logic       last_word;

    assign cfg_ok    = (kernel_size != 8'd0) && (kernel_size <= K_MAX) &&
                       (num_channel != 8'd0);
    assign handshake = (state == S_SEND) && out_ready;
    assign col_last  = (col_cnt == k_reg - 8'd1);
    assign row_last  = (row_cnt == k_reg - 8'd1);
    assign ch_last   = (ch_cnt  == c_reg - 8'd1);
    assign last_word = col_last && row_last && ch_last;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only,
        // so every register samples pre-edge values regardless of block order.
        if (!rstn) begin
            state    <= S_IDLE;
            k_reg    <= 8'd0;
            c_reg    <= 8'd0;
            col_cnt  <= 8'd0;
            row_cnt  <= 8'd0;
            ch_cnt   <= 8'd0;
            out_row  <= '0;
            out_col  <= '0;
            out_data <= '0;
            cfg_err  <= 1'b0;
        end else begin
            state   <= state_next;
            cfg_err <= cfg_err_next;

            if (accept) begin
                k_reg   <= kernel_size;
                c_reg   <= num_channel;
                col_cnt <= 8'd0;
                row_cnt <= 8'd0;
                ch_cnt  <= 8'd0;
            end

            // FIFO data popped last cycle is valid now; capture it with its tag.
            if (state == S_WAIT) begin
                out_data <= fifo_dout;
                out_row  <= row_cnt[RW-1:0];
                out_col  <= col_cnt[CW-1:0];
            end

            if (handshake) begin
                if (col_last) begin
                    col_cnt <= 8'd0;
                    if (row_last) begin
                        row_cnt <= 8'd0;
                        ch_cnt  <= ch_cnt + 8'd1;
                    end else begin
                        row_cnt <= row_cnt + 8'd1;
                    end
                end else begin
                    col_cnt <= col_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_next   = state;
        fifo_rd_en   = 1'b0;
        out_valid    = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        cfg_err_next = 1'b0;
        accept       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        accept     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_word) begin
                        state_next = S_DONE;
                    end else if (!fifo_empty) begin
                        // Pop the next word during the handshake to skip FETCH.
                        fifo_rd_en = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xy_tag_sched.sv
// Scoreboard bench for xy_tag_sched: a FIFO model feeds the DUT, stimulus pushes
// expected tagged words, and a negedge monitor compares every presented word.
module tb_xy_tag_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  kernel_size;
    logic [7:0]  num_channel;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        cfg_err;

    xy_tag_sched #(.DATA_WIDTH(16), .NUM_COL(4), .NUM_ROW(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .kernel_size(kernel_size),
        .num_channel(num_channel),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int cfg_cnt  = 0;
    int p0, a0, d0, e0;

    // Source FIFO model: registered read data, one cycle after the pop strobe.
    logic [31:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic rand_en     = 1'b0;
    logic ready_fixed = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (fifo_rd_en) begin
                check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
                pop_cnt++;
            end
            if (done)    done_cnt++;
            if (cfg_err) cfg_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("tag_row", 64'(out_row),  64'(exp_q[0].row));
                    check("tag_col", 64'(out_col),  64'(exp_q[0].col));
                    check("data",    64'(out_data), 64'(exp_q[0].data));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [2:0] r, input logic [2:0] c);
        exp_t e;
        fifo_mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
        e.row  = r;
        e.col  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int k, input int nch, input logic [31:0] base);
        int n = 0;
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < k; r++)
                for (int c = 0; c < k; c++) begin
                    push_word(base + 32'(n), 3'(r), 3'(c));
                    n++;
                end
    endtask

    task automatic do_start(input logic [7:0] k, input logic [7:0] nch);
        start       = 1'b1;
        kernel_size = k;
        num_channel = nch;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        tick();
        check("done_single_pulse", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic snap();
        p0 = pop_cnt;
        a0 = acc_cnt;
        d0 = done_cnt;
        e0 = cfg_cnt;
    endtask

    task automatic expect_delta(input int words, input int dones, input int errs);
        check("pops",           64'(pop_cnt - p0),  64'(words));
        check("words",          64'(acc_cnt - a0),  64'(words));
        check("done_pulses",    64'(done_cnt - d0), 64'(dones));
        check("cfg_err_pulses", 64'(cfg_cnt - e0),  64'(errs));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   64'(fifo_rd_en), 64'd0);
        check({tag, "_valid"},   64'(out_valid),  64'd0);
        check({tag, "_row"},     64'(out_row),    64'd0);
        check({tag, "_col"},     64'(out_col),    64'd0);
        check({tag, "_data"},    64'(out_data),   64'd0);
        check({tag, "_busy"},    64'(busy),       64'd0);
        check({tag, "_done"},    64'(done),       64'd0);
        check({tag, "_cfg_err"}, 64'(cfg_err),    64'd0);
    endtask

    task automatic reject_cfg(input logic [7:0] k, input logic [7:0] nch, input string tag);
        do_start(k, nch);
        check({tag, "_cfg_err_pulse"}, 64'(cfg_err), 64'd1);
        check({tag, "_busy_low"},      64'(busy),    64'd0);
        tick();
        check({tag, "_cfg_err_clear"}, 64'(cfg_err), 64'd0);
        check({tag, "_still_idle"},    64'(busy),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] t_row [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [2:0] t_col [4] = '{3'd0, 3'd1, 3'd0, 3'd1};

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        kernel_size = 8'd0;
        num_channel = 8'd0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // k=2, C=1 with preloaded FIFO: latency and 2x2 tag order.
        snap();
        for (int i = 0; i < 4; i++) push_word(32'hA5A5_0000 + 32'(i), t_row[i], t_col[i]);
        do_start(8'd2, 8'd1);
        check("lat_c1_busy",  64'(busy),       64'd1);
        check("lat_c1_rd_en", 64'(fifo_rd_en), 64'd1);
        check("lat_c1_valid", 64'(out_valid),  64'd0);
        tick();
        check("lat_c2_valid", 64'(out_valid),  64'd0);
        check("lat_c2_rd_en", 64'(fifo_rd_en), 64'd0);
        tick();
        check("lat_c3_valid", 64'(out_valid),  64'd1);
        wait_done(100);
        expect_delta(4, 1, 0);

        // k=3, C=2 with random backpressure: two 3x3 sweeps.
        snap();
        push_sweep(3, 2, 32'h3000_0000);
        rand_en = 1'b1;
        do_start(8'd3, 8'd2);
        wait_done(1000);
        rand_en = 1'b0;
        tick();
        expect_delta(18, 1, 0);

        // Rejected configurations, with a word waiting in the FIFO.
        snap();
        push_word(32'h0000_BEEF, 3'd0, 3'd0);
        reject_cfg(8'd5, 8'd1, "k5");
        reject_cfg(8'd2, 8'd0, "c0");
        reject_cfg(8'd0, 8'd1, "k0");
        check("cfg_no_pops",    64'(pop_cnt - p0), 64'd0);
        check("cfg_err_count",  64'(cfg_cnt - e0), 64'd3);

        // k=1, C=1 consumes that word as a single (0,0) transfer.
        snap();
        do_start(8'd1, 8'd1);
        wait_done(100);
        expect_delta(1, 1, 0);

        // k=2, C=1 with an empty FIFO for 10 cycles.
        snap();
        do_start(8'd2, 8'd1);
        for (int i = 0; i < 10; i++) begin
            check("starve_rd_en", 64'(fifo_rd_en), 64'd0);
            check("starve_valid", 64'(out_valid),  64'd0);
            check("starve_busy",  64'(busy),       64'd1);
            tick();
        end
        push_sweep(2, 1, 32'h5500_0000);
        wait_done(100);
        expect_delta(4, 1, 0);

        // Reset while the 3rd word of a k=3 transfer sits in SEND.
        snap();
        push_sweep(2, 1, 32'h7000_0000);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        wr_ptr = wr_ptr - 2;
        do_start(8'd3, 8'd1);
        begin
            int n = 0;
            while (acc_cnt - a0 < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_two_words", 64'(acc_cnt - a0), 64'd2);
        ready_fixed = 1'b0;
        tick();
        tick();
        push_word(32'h7000_0002, 3'd0, 3'd2);
        begin
            int n = 0;
            while (out_valid !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_third_in_send", 64'(out_valid), 64'd1);
        tick();
        rstn = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rstn = 1'b1;
        exp_q.delete();
        check("midrst_pops", 64'(pop_cnt - p0), 64'd3);
        ready_fixed = 1'b1;
        tick();
        tick();
        check("midrst_no_resume", 64'(busy), 64'd0);

        snap();
        push_sweep(2, 1, 32'h9900_0000);
        do_start(8'd2, 8'd1);
        wait_done(100);
        expect_delta(4, 1, 0);

        // start while busy must be ignored.
        snap();
        push_sweep(2, 1, 32'hC000_0000);
        do_start(8'd2, 8'd1);
        start       = 1'b1;
        kernel_size = 8'd3;
        num_channel = 8'd1;
        tick();
        start = 1'b0;
        wait_done(100);
        repeat (3) tick();
        check("busy_start_ignored", 64'(busy), 64'd0);
        expect_delta(4, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
